// File: rtl/regfile_2w2r.sv
// Two-write, two-read register file with write-to-read bypass and a reset
// sweep that clears every register before normal operation begins.
module regfile_2w2r #(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int BYPASS        = 1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [ADDRESS_WIDTH-1:0] RA,
  input  logic [ADDRESS_WIDTH-1:0] RB,
  output logic [DATA_WIDTH-1:0]    BusA,
  output logic [DATA_WIDTH-1:0]    BusB,
  input  logic [ADDRESS_WIDTH-1:0] RW0,
  input  logic [DATA_WIDTH-1:0]    BusW0,
  input  logic                     RegWr0,
  input  logic [ADDRESS_WIDTH-1:0] RW1,
  input  logic [DATA_WIDTH-1:0]    BusW1,
  input  logic                     RegWr1,
  output logic                     Busy
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX  = ADDRESS_WIDTH'(DEPTH - 1);
  localparam logic [ADDRESS_WIDTH-1:0] FIRST_IDX = ADDRESS_WIDTH'(1);

  logic [0:0]               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] idx_q, idx_d;
  logic                     busy_q, busy_d;
  logic [DATA_WIDTH-1:0]    regs_q [DEPTH];
  logic [DATA_WIDTH-1:0]    regs_d [DEPTH];
  logic                     we0, we1;

  function automatic logic [DATA_WIDTH-1:0] read_sel(
    input logic [ADDRESS_WIDTH-1:0] raddr,
    input logic [DATA_WIDTH-1:0]    stored,
    input logic                     busy,
    input logic                     wr0,
    input logic [ADDRESS_WIDTH-1:0] waddr0,
    input logic [DATA_WIDTH-1:0]    wdata0,
    input logic                     wr1,
    input logic [ADDRESS_WIDTH-1:0] waddr1,
    input logic [DATA_WIDTH-1:0]    wdata1
  );
    logic [DATA_WIDTH-1:0] r;
    r = stored;
    if (raddr == '0 || busy) begin
      r = '0;
    end else if (BYPASS != 0 && wr1 && waddr1 == raddr) begin
      r = wdata1;
    end else if (BYPASS != 0 && wr0 && waddr0 == raddr) begin
      r = wdata0;
    end
    return r;
  endfunction

  // Sweep sequencer: idx walks 1..DEPTH-1 and never wraps onto register 0
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == ST_CLEAR) begin
      if (idx_q == LAST_IDX) begin
        state_d = ST_RUN;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
    busy_d = (state_d == ST_CLEAR);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_CLEAR;
      idx_q   <= FIRST_IDX;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
    end
  end

  // Port 1 is applied last so it wins a same-address collision
  assign we0 = RegWr0 && (RW0 != '0);
  assign we1 = RegWr1 && (RW1 != '0);

  always_comb begin
    regs_d = regs_q;
    if (!Reset) begin
      if (state_q == ST_CLEAR) begin
        regs_d[idx_q] = '0;
      end else begin
        if (we0) regs_d[RW0] = BusW0;
        if (we1) regs_d[RW1] = BusW1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    regs_q <= regs_d;
  end

  always_comb begin
    BusA = read_sel(RA, regs_q[RA], busy_q, RegWr0, RW0, BusW0, RegWr1, RW1, BusW1);
    BusB = read_sel(RB, regs_q[RB], busy_q, RegWr0, RW0, BusW0, RegWr1, RW1, BusW1);
  end

  assign Busy = busy_q;

endmodule

// File: doc/regfile_2w2r.md
# regfile_2w2r

Two-write, two-read register file for the pipelined MIPS core, replacing the single-write-port file so that the writeback stage and a second producer can retire in the same cycle. Adds a parametrised write-to-read bypass and a self-clearing reset sequencer, so that after reset every register reads zero without relying on simulation-only initialisation. It sits between decode (reads) and writeback (writes). Register 0 stays hardwired to zero.

## Interface
- DATA_WIDTH, 32, register width in bits
- DEPTH, 32, number of registers (power of two, ≥ 4)
- ADDRESS_WIDTH, 5, register address width; DEPTH == 2**ADDRESS_WIDTH
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads see stored contents only

Ports:
- Clk  input  1  clock; all state updates on the rising edge
- Reset  input  1  synchronous, active-high reset
- RA  input  ADDRESS_WIDTH  read address, port A
- RB  input  ADDRESS_WIDTH  read address, port B
- BusA  output  DATA_WIDTH  read data, port A (combinational)
- BusB  output  DATA_WIDTH  read data, port B (combinational)
- RW0  input  ADDRESS_WIDTH  write address, port 0
- BusW0  input  DATA_WIDTH  write data, port 0
- RegWr0  input  1  write enable, port 0
- RW1  input  ADDRESS_WIDTH  write address, port 1
- BusW1  input  DATA_WIDTH  write data, port 1
- RegWr1  input  1  write enable, port 1
- Busy  output  1  clear sweep in progress; writes ignored, reads return 0

## Operation
- One clock, Clk. Reset is synchronous and active-high.
- Two-state FSM:
  - CLEAR: entered at any edge with Reset=1. The sweep index idx is loaded to 1.
  - CLEAR with Reset=0: each edge writes reg[idx]=0 and increments idx. At the edge that clears reg[DEPTH-1], the FSM moves to RUN.
  - RUN: normal operation. Moves back to CLEAR only on Reset.
- Busy = (state == CLEAR). It is registered and reset to 1.
- Writes in RUN, on the rising edge:
  - Port 0 writes BusW0 to reg[RW0] if RegWr0=1 and RW0≠0.
  - Port 1 writes BusW1 to reg[RW1] if RegWr1=1 and RW1≠0.
  - If both ports are enabled with the same nonzero address, port 1 wins and port 0 is dropped.
- Writes in CLEAR: both user write ports are ignored entirely.
- Read value for port X (A or B), address RX, evaluated in this priority order:
  1. RX==0 or Busy=1 → 0.
  2. BYPASS=1, RegWr1=1 and RW1==RX → BusW1.
  3. BYPASS=1, RegWr0=1 and RW0==RX → BusW0.
  4. Otherwise → reg[RX].
- Register 0 is never written and always reads 0, including through bypass.
- Width rules: no arithmetic on data. idx is ADDRESS_WIDTH bits wide; it stops at DEPTH-1 and does not wrap into register 0.

## Timing
- Reset values: Busy=1, state=CLEAR, idx=1. BusA and BusB are 0 while Busy=1.
- Sweep duration: exactly DEPTH-1 edges with Reset=0. Busy falls after the (DEPTH-1)th such edge; for DEPTH=32 that is 31 cycles.
- The first user write is accepted at the first edge with Busy=0.
- Reset mid-sweep: at the edge where Reset=1, idx goes back to 1. The sweep then restarts in full; there is no partial resume.
- Reset held high: Busy stays 1 and no registers are cleared until Reset falls.
- Read latency: 0 cycles, combinational from RA/RB and storage.
- Write-to-read latency:
  - BYPASS=1: visible in the same cycle as the write.
  - BYPASS=0: visible the cycle after the write edge.
- Simultaneous read and write to the same address with BYPASS=0: the read returns the old value during that cycle.

## Test plan
- Reset, then hold Reset=0 → Busy=1 for 31 cycles and 0 from cycle 32. Reading registers 1..31 then returns 0x00000000.
- Deassert Reset; on sweep cycle 10 reassert Reset for 1 cycle → sweep restarts. Busy stays 1 for 31 cycles after the second deassertion.
- In RUN, write RW0=5/0xDEADBEEF and RW1=6/0x12345678 in the same cycle → next cycle RA=5 reads 0xDEADBEEF and RB=6 reads 0x12345678.
- Collision: RW0=RW1=7, BusW0=0x1111, BusW1=0x2222 → reg7 reads 0x2222. With BYPASS=1 and RA=7 in the same cycle, BusA=0x2222.
- BYPASS=1: write reg9=0xA5A5 while RB=9 → BusB=0xA5A5 in the same cycle. With BYPASS=0 → old value that cycle, 0xA5A5 the next.
- Write to register 0 (0xFFFFFFFF on both ports) → RA=0 reads 0. Writes issued while Busy=1 → target register still 0 after the sweep.
